ibuffer_mq: RTL and testbench

Parametrised multi-lane instruction buffer between fetch and decode. Accepts up to ENQ_W instructions per cycle from the fetch group, with arbitrary lane masks compacted in lane order. Presents up to DEQ_W oldest instructions per cycle to decode, which pops a variable number of them. Supports synchronous flush on redirect and an almost-full flag for fetch throttling.

---
 rtl/ibuffer_mq.sv | 137 +++++++++++++
 tb/tb_ibuffer_mq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuffer_mq.sv
// ibuffer_mq: multi-lane instruction buffer between fetch and decode.
//
// Fetch writes up to ENQ_W entries per cycle. Set lanes are packed in
// ascending lane order, so a sparse mask leaves no hole in storage.
// Decode sees the DEQ_W oldest entries and pops 0..DEQ_W of them per cycle.
// A pop request larger than the number of valid lanes is clamped.
// The buffer is a circular array of DEPTH entries. DEPTH need not be a
// power of two.
//
// Ports:
//   clock, reset_n    rising-edge clock; asynchronous active-low reset
//   flush             synchronous clear of pointers and count (redirect)
//   enq_valid/data    per-lane fetch valids and packed lane payloads
//   enq_ready         at least ENQ_W free entries (from registered count)
//   deq_valid/data    prefix mask and the oldest DEQ_W entries (lane 0 oldest)
//   deq_take          number of decode lanes consumed this cycle
//   count             occupancy
//   empty, full       occupancy status flags
//   almost_full       free entries below AF_MARGIN
module ibuffer_mq #(
    parameter int unsigned DATA_W    = 96,
    parameter int unsigned DEPTH     = 48,
    parameter int unsigned ENQ_W     = 4,
    parameter int unsigned DEQ_W     = 2,
    parameter int unsigned AF_MARGIN = 8,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [ENQ_W-1:0]           enq_valid,
    input  logic [ENQ_W*DATA_W-1:0]    enq_data,
    output logic                       enq_ready,
    output logic [DEQ_W-1:0]           deq_valid,
    output logic [DEQ_W*DATA_W-1:0]    deq_data,
    input  logic [$clog2(DEQ_W+1)-1:0] deq_take,
    output logic [CNT_W-1:0]           count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LANE_W = $clog2(ENQ_W + 1);
    localparam int unsigned TAKE_W = $clog2(DEQ_W + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;

    logic [LANE_W-1:0] lane_off [ENQ_W];
    logic [LANE_W-1:0] n_in;
    logic [LANE_W-1:0] n_in_eff;
    logic [TAKE_W-1:0] n_avail;
    logic [TAKE_W-1:0] n_out;
    logic [31:0]       free_cnt;
    logic              enq_fire;

    // Modulo-DEPTH pointer advance. inc never exceeds DEPTH, so one
    // conditional subtract is enough.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned      inc);
        int unsigned sum;
        sum = 32'(base) + inc;
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return PTR_W'(sum);
    endfunction

    // Status flags derived from registered occupancy only.
    assign free_cnt    = 32'(DEPTH) - 32'(count_q);
    assign enq_ready   = (free_cnt >= 32'(ENQ_W));
    assign almost_full = (free_cnt < 32'(AF_MARGIN));
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign count       = count_q;

    // Lane compaction: each set lane goes to the slot given by the number of
    // set lanes below it.
    always_comb begin
        n_in = '0;
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            lane_off[i] = n_in;
            n_in        = n_in + LANE_W'(enq_valid[i]);
        end
    end

    assign enq_fire = enq_ready && (|enq_valid) && !flush;
    assign n_in_eff = enq_fire ? n_in : '0;

    // Pop amount: at most the number of valid lanes.
    assign n_avail = (32'(count_q) >= 32'(DEQ_W)) ? TAKE_W'(DEQ_W) : TAKE_W'(count_q);
    assign n_out   = (deq_take < n_avail) ? deq_take : n_avail;

    // Read the oldest entries. Invalid lanes drive zero to hide stale data.
    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            deq_valid[i] = (32'(count_q) > i);
            if (deq_valid[i]) begin
                deq_data[i*DATA_W +: DATA_W] = mem[ptr_add(rd_ptr, i)];
            end
        end
    end

    // Entry storage. It is never cleared, because reads are masked by count.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            for (int unsigned i = 0; i < ENQ_W; i++) begin
                if (enq_valid[i]) begin
                    mem[ptr_add(wr_ptr, 32'(lane_off[i]))] <= enq_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Pointers and occupancy. Flush takes priority over a same-cycle push or pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= ptr_add(rd_ptr, 32'(n_out));
            wr_ptr  <= ptr_add(wr_ptr, 32'(n_in_eff));
            count_q <= count_q + CNT_W'(n_in_eff) - CNT_W'(n_out);
        end
    end

endmodule

// File: tb/tb_ibuffer_mq.sv
// Directed testbench for ibuffer_mq with the default parameters
// (DATA_W=96, DEPTH=48, ENQ_W=4, DEQ_W=2, AF_MARGIN=8).
module tb_ibuffer_mq;

    localparam int DW = 96;

    logic           clock;
    logic           reset_n;
    logic           flush;
    logic [3:0]     enq_valid;
    logic [4*DW-1:0] enq_data;
    logic           enq_ready;
    logic [1:0]     deq_valid;
    logic [2*DW-1:0] deq_data;
    logic [1:0]     deq_take;
    logic [5:0]     count;
    logic           empty;
    logic           full;
    logic           almost_full;

    int n_checks = 0;
    int n_fail   = 0;

    ibuffer_mq dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_data    (enq_data),
        .enq_ready   (enq_ready),
        .deq_valid   (deq_valid),
        .deq_data    (deq_data),
        .deq_take    (deq_take),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Entry payload: {instruction, pc}. The instruction is derived from the pc.
    function automatic logic [DW-1:0] mk(input logic [63:0] pc);
        return {pc[31:0] ^ 32'h1357_9BDF, pc};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int l, input logic [63:0] pc);
        enq_data[l*DW +: DW] = mk(pc);
    endtask

    // Lane l carries pc base+4*l. Only the lanes set in mask are enqueued.
    task automatic push(input logic [3:0] mask, input logic [63:0] base);
        for (int l = 0; l < 4; l++) set_lane(l, base + 64'(4 * l));
        enq_valid = mask;
        tick();
        enq_valid = '0;
    endtask

    task automatic pop(input int n);
        deq_take = 2'(n);
        tick();
        deq_take = '0;
    endtask

    task automatic chk_two(input string tag, input logic [63:0] pc0, input logic [63:0] pc1);
        chk({tag, "_valid"}, 192'(deq_valid), 192'(2'b11));
        chk({tag, "_data"}, deq_data, {mk(pc1), mk(pc0)});
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        enq_valid = '0;
        enq_data  = '0;
        deq_take  = '0;

        // Values while reset is held low
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", 192'(count), 192'(0));
        chk("rst_empty", 192'(empty), 192'(1));
        chk("rst_full", 192'(full), 192'(0));
        chk("rst_ready", 192'(enq_ready), 192'(1));
        chk("rst_af", 192'(almost_full), 192'(0));
        chk("rst_dvalid", 192'(deq_valid), 192'(0));
        chk("rst_ddata", deq_data, 192'(0));
        reset_n = 1'b1;

        // Full-width enqueue. Nothing is visible before the clock edge.
        for (int l = 0; l < 4; l++) set_lane(l, 64'h100 + 64'(4 * l));
        enq_valid = 4'b1111;
        deq_take  = 2'd2;
        #1;
        chk("nobypass_count", 192'(count), 192'(0));
        chk("nobypass_valid", 192'(deq_valid), 192'(0));
        tick();
        enq_valid = '0;
        deq_take  = '0;
        chk("enq4_count", 192'(count), 192'(4));
        chk_two("enq4", 64'h100, 64'h104);
        pop(2);
        chk("pop2_count", 192'(count), 192'(2));
        chk_two("pop2", 64'h108, 64'h10C);

        // Sparse mask 1010 compacts to two adjacent entries, lane1 first.
        for (int l = 0; l < 4; l++) set_lane(l, 64'h900 + 64'(l));
        set_lane(1, 64'h200);
        set_lane(3, 64'h204);
        enq_valid = 4'b1010;
        tick();
        enq_valid = '0;
        chk("sparse_count", 192'(count), 192'(4));
        pop(2);
        chk_two("sparse", 64'h200, 64'h204);
        pop(2);
        chk("sparse_empty", 192'(empty), 192'(1));

        // Fill to 45 entries (pcs 0x1000 + 4k, k = 0..44).
        for (int j = 0; j < 11; j++) push(4'b1111, 64'h1000 + 64'(16 * j));
        chk("fill44_ready", 192'(enq_ready), 192'(1));
        push(4'b0001, 64'h1000 + 64'(4 * 44));
        chk("fill45_count", 192'(count), 192'(45));
        chk("fill45_ready", 192'(enq_ready), 192'(0));
        chk("fill45_af", 192'(almost_full), 192'(1));
        push(4'b1111, 64'hBAD0);
        chk("notready_count", 192'(count), 192'(45));
        pop(2);
        chk("pop43_count", 192'(count), 192'(43));
        chk("pop43_ready", 192'(enq_ready), 192'(1));
        chk_two("pop43", 64'h1008, 64'h100C);
        push(4'b1111, 64'h1000 + 64'(4 * 45));
        chk("fill47_count", 192'(count), 192'(47));
        chk("fill47_full", 192'(full), 192'(0));
        chk("fill47_ready", 192'(enq_ready), 192'(0));

        // Drain in order across the wrap point (k = 2..48).
        for (int j = 0; j < 23; j++) begin
            chk_two("drain", 64'h1000 + 64'(4 * (2 + 2 * j)), 64'h1000 + 64'(4 * (3 + 2 * j)));
            pop(2);
        end
        chk("drain1_count", 192'(count), 192'(1));
        chk("drain1_valid", 192'(deq_valid), 192'(2'b01));
        chk("drain1_data", deq_data, {96'(0), mk(64'h1000 + 64'(4 * 48))});

        // Clamped pop with a concurrent 3-lane enqueue
        for (int l = 0; l < 4; l++) set_lane(l, 64'h2000 + 64'(4 * l));
        enq_valid = 4'b0111;
        deq_take  = 2'd2;
        tick();
        enq_valid = '0;
        deq_take  = '0;
        chk("clamp_count", 192'(count), 192'(3));
        chk_two("clamp", 64'h2000, 64'h2004);
        pop(2);
        chk("clamp_tail", deq_data, {96'(0), mk(64'h2008)});
        pop(1);
        chk("clamp_empty", 192'(empty), 192'(1));

        // Move both pointers to 46, then wrap a 4-lane write.
        for (int j = 0; j < 9; j++) begin
            push(4'b1111, 64'h5000);
            pop(2);
            pop(2);
        end
        chk("prewrap_count", 192'(count), 192'(0));
        push(4'b1111, 64'h300);
        chk("wrap_count", 192'(count), 192'(4));
        chk_two("wrap_a", 64'h300, 64'h304);
        pop(2);
        chk_two("wrap_b", 64'h308, 64'h30C);
        pop(2);
        push(4'b0001, 64'h310);
        chk("wrap_next", deq_data, {96'(0), mk(64'h310)});
        pop(1);

        // Flush overrides a same-cycle push and pop.
        push(4'b1111, 64'h600);
        push(4'b1111, 64'h610);
        push(4'b0011, 64'h620);
        chk("preflush_count", 192'(count), 192'(10));
        for (int l = 0; l < 4; l++) set_lane(l, 64'h680 + 64'(4 * l));
        flush     = 1'b1;
        enq_valid = 4'b1111;
        deq_take  = 2'd2;
        tick();
        flush     = 1'b0;
        enq_valid = '0;
        deq_take  = '0;
        chk("flush_count", 192'(count), 192'(0));
        chk("flush_empty", 192'(empty), 192'(1));
        chk("flush_valid", 192'(deq_valid), 192'(0));
        chk("flush_data", deq_data, 192'(0));
        tick();
        chk("flush_hold", 192'(count), 192'(0));
        push(4'b0001, 64'h700);
        chk("postflush", deq_data, {96'(0), mk(64'h700)});
        pop(1);

        // Completely full buffer
        for (int j = 0; j < 12; j++) push(4'b1111, 64'h7000 + 64'(16 * j));
        chk("full_count", 192'(count), 192'(48));
        chk("full_flag", 192'(full), 192'(1));
        chk("full_ready", 192'(enq_ready), 192'(0));
        chk_two("full_head", 64'h7000, 64'h7004);

        // Asynchronous reset in mid-cycle, then enqueue on the first edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 192'(count), 192'(0));
        chk("arst_full", 192'(full), 192'(0));
        chk("arst_valid", 192'(deq_valid), 192'(0));
        chk("arst_data", deq_data, 192'(0));
        for (int l = 0; l < 4; l++) set_lane(l, 64'hA00 + 64'(4 * l));
        enq_valid = 4'b1111;
        #2;
        reset_n = 1'b1;
        tick();
        enq_valid = '0;
        chk("postrst_count", 192'(count), 192'(4));
        chk_two("postrst", 64'hA00, 64'hA04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
